// File: rtl/ifetch_prefetch_buffer_pkg.sv
// Shared fetch-path constants: datapath width, default boot PC, canonical NOP and PC increment.
package ifetch_prefetch_buffer_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, registered head, one-cycle write-to-read latency.
// A push while full is accepted only together with a pop; a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Sequential prefetcher feeding decode: response-to-instr_valid latency 1 cycle, no bypass.
// Requests are credit-limited so every response has a slot; the core stalls via instr_ready.
module ifetch_prefetch_buffer #(
    parameter int                                      XLEN     = ifetch_prefetch_buffer_pkg::XLEN,
    parameter int                                      DEPTH    = 2,
    parameter logic [ifetch_prefetch_buffer_pkg::XLEN-1:0] RESET_PC = ifetch_prefetch_buffer_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    import ifetch_prefetch_buffer_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] head_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            issue;
    logic            drop;
    logic            push;
    logic            pop;

    assign req_valid = !rst && !redirect_valid && !fifo_full &&
                       (((CW+1)'(fifo_count) + (CW+1)'(outstanding)) < (CW+1)'(DEPTH));
    assign issue     = req_valid && req_ready;
    assign drop      = redirect_valid || (discard != '0);
    assign push      = rsp_valid && !drop;
    assign pop       = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = !fifo_empty;
    assign req_addr    = fetch_pc;
    assign instr_pc    = head_pc;

    assign outstanding_nxt = outstanding + CW'(issue) - CW'(rsp_valid);

    // After a redirect every request still in flight belongs to the old stream,
    // so the discard count becomes exactly the post-accounting outstanding count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                head_pc  <= redirect_pc;
                discard  <= outstanding_nxt;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                end
                if (pop) begin
                    head_pc <= head_pc + XLEN'(PC_STEP);
                end
                if (rsp_valid && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (rsp_data),
        .dout  (instr),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    a_rsp_needs_outstanding : assert property (@(posedge clk) disable iff (rst)
        rsp_valid |-> (outstanding != '0));
    a_req_addr_aligned : assert property (@(posedge clk) disable iff (rst)
        req_addr[1:0] == 2'b00);
    a_redirect_aligned : assert property (@(posedge clk) disable iff (rst)
        redirect_valid |-> (redirect_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Directed bench for the prefetch buffer with a 1-cycle memory model and in-order scoreboard.
module tb_ifetch_prefetch_buffer;

    import ifetch_prefetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int          checks   = 0;
    int          failures = 0;
    int          consumed = 0;
    bit          mem_en   = 1'b1;
    bit          got_first;
    logic [31:0] first_pc;
    logic [31:0] exp_fetch;
    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];

    ifetch_prefetch_buffer #(
        .XLEN     (32),
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return INSTR_NOP ^ (a * 32'h9E37_79B1) ^ {a[15:0], 16'h0000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory response, sample at negedge, account, then advance past posedge.
    task automatic step();
        logic [31:0] e;
        if (mem_en && mem_q.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mem_q[0]);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        @(negedge clk);
        if (redirect_valid) chk("no_req_on_redirect", 32'(req_valid), 32'd0);
        if (req_valid && req_ready) begin
            chk("req_addr", req_addr, exp_fetch);
            mem_q.push_back(req_addr);
            exp_q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rsp_valid) void'(mem_q.pop_front());
        if (instr_valid && instr_ready && !redirect_valid) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e);
                chk("instr", instr, mem_word(e));
                if (!got_first) begin
                    first_pc  = instr_pc;
                    got_first = 1'b1;
                end
                consumed++;
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            exp_fetch = redirect_pc;
            got_first = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        exp_fetch = 32'h0; got_first = 1'b0; first_pc = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        rst = 1'b0;
        #1;
        chk("req_valid_after_rst", 32'(req_valid), 32'd1);

        // Zero-wait memory, core always ready
        req_ready = 1'b1; instr_ready = 1'b1; consumed = 0;
        repeat (12) step();
        chk("steady_first_pc", first_pc, 32'h0);
        chk("steady_throughput", 32'(consumed >= 6), 32'd1);

        // Core stall fills the FIFO and stops fetch
        instr_ready = 1'b0;
        repeat (6) step();
        chk("stall_instr_valid", 32'(instr_valid), 32'd1);
        chk("stall_req_valid", 32'(req_valid), 32'd0);
        chk("stall_sb_depth", 32'(exp_q.size()), 32'd2);
        chk("stall_head_pc", instr_pc, (exp_q.size() != 0) ? exp_q[0] : 32'hFFFF_FFFF);
        instr_ready = 1'b1;
        repeat (8) step();

        // Memory not ready: address held, nothing returns
        req_ready = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_req_valid", 32'(req_valid), 32'd1);
            chk("hold_req_addr", req_addr, exp_fetch);
            chk("hold_no_instr", 32'(instr_valid), 32'd0);
        end
        req_ready = 1'b1;
        repeat (6) step();

        // Two requests outstanding, then redirect to 0x100
        req_ready = 1'b0;
        repeat (4) step();
        mem_en = 1'b0; req_ready = 1'b1;
        repeat (3) step();
        chk("two_out_req_valid", 32'(req_valid), 32'd0);
        chk("two_out_inflight", 32'(mem_q.size()), 32'd2);
        redirect_to(32'h0000_0100);
        chk("redir1_flushed", 32'(instr_valid), 32'd0);
        chk("redir1_instr_pc", instr_pc, 32'h0000_0100);
        chk("redir1_req_addr", req_addr, 32'h0000_0100);
        mem_en = 1'b1;
        repeat (10) step();
        chk("redir1_first_pc", first_pc, 32'h0000_0100);

        // Redirect coinciding with a response and a pop
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid && mem_q.size() > 0) found = 1'b1;
            else step();
        end
        chk("coincide_setup", 32'(found), 32'd1);
        redirect_to(32'h0000_0180);
        chk("redir2_flushed", 32'(instr_valid), 32'd0);
        chk("redir2_instr_pc", instr_pc, 32'h0000_0180);
        repeat (10) step();
        chk("redir2_first_pc", first_pc, 32'h0000_0180);

        // Back-to-back redirects with one request outstanding
        req_ready = 1'b0;
        repeat (4) step();
        mem_en = 1'b0; req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("b2b_inflight", 32'(mem_q.size()), 32'd1);
        redirect_to(32'h0000_0200);
        redirect_to(32'h0000_0300);
        mem_en = 1'b1; req_ready = 1'b1;
        repeat (12) step();
        chk("b2b_first_pc", first_pc, 32'h0000_0300);
        chk("b2b_delivered", 32'(got_first), 32'd1);

        // Reset while idle returns everything to reset values
        req_ready = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_req_valid", 32'(req_valid), 32'd0);
        chk("rst2_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst2_req_addr", req_addr, 32'h0);
        chk("rst2_instr_pc", instr_pc, 32'h0);
        chk("rst2_instr", instr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
